// File: rtl/axil_demux_pkg.sv
// Shared types, response codes and address decode for the AXI-lite 1-to-N demultiplexer.
package axil_demux_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_BACK} r_state_e;

  // Port index is the idx_bits-wide field just above the per-port window.
  function automatic int decode_index(input logic [63:0] addr, input int win_bits,
                                      input int idx_bits);
    logic [63:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return int'((addr >> win_bits) & mask);
  endfunction

endpackage

// File: rtl/axil_demux_wdog.sv
// Per-channel watchdog: counts enabled cycles since the last clear and flags expiry at TIMEOUT.
module axil_demux_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // The cycle that sees count == TIMEOUT-1 is the TIMEOUT-th enabled cycle.
  assign expire = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_demux.sv
// AXI-lite 1-to-N address demux, one outstanding write and one outstanding read.
// Optional per-channel watchdog enabled by defining AXIL_DEMUX_TIMEOUT_EN.
module axil_demux
  import axil_demux_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int WIN_BITS       = 12,
  parameter int BASE_IDX_LIMIT = NUM_PORTS,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
`ifdef AXIL_DEMUX_TIMEOUT_EN
  , parameter int TIMEOUT      = 1024
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [STRB_WIDTH-1:0]            s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_awaddr,
  output logic [NUM_PORTS-1:0]             m_awvalid,
  input  logic [NUM_PORTS-1:0]             m_awready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  m_wdata,
  output logic [NUM_PORTS*STRB_WIDTH-1:0]  m_wstrb,
  output logic [NUM_PORTS-1:0]             m_wvalid,
  input  logic [NUM_PORTS-1:0]             m_wready,
  input  logic [NUM_PORTS*2-1:0]           m_bresp,
  input  logic [NUM_PORTS-1:0]             m_bvalid,
  output logic [NUM_PORTS-1:0]             m_bready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_araddr,
  output logic [NUM_PORTS-1:0]             m_arvalid,
  input  logic [NUM_PORTS-1:0]             m_arready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_rdata,
  input  logic [NUM_PORTS*2-1:0]           m_rresp,
  input  logic [NUM_PORTS-1:0]             m_rvalid,
  output logic [NUM_PORTS-1:0]             m_rready
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  // ---------------- write channel ----------------
  w_state_e                w_state, w_next;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic [IDX_W-1:0]        w_idx_q, aw_idx;
  logic                    aw_hit, aw_done, w_done;
  logic [1:0]              b_resp_q;
  logic [NUM_PORTS-1:0]    w_sel;
  logic                    w_expire;

  assign aw_idx    = IDX_W'(decode_index(64'(s_awaddr), WIN_BITS, IDX_W));
  assign aw_hit    = int'(aw_idx) < BASE_IDX_LIMIT;
  assign s_awready = (w_state == W_IDLE) && s_awvalid && s_wvalid;
  assign s_wready  = s_awready;
  assign s_bvalid  = (w_state == W_BACK);
  assign s_bresp   = b_resp_q;

  assign w_sel     = NUM_PORTS'(1) << w_idx_q;
  assign m_awvalid = (w_state == W_FWD && !aw_done) ? w_sel : '0;
  assign m_wvalid  = (w_state == W_FWD && !w_done) ? w_sel : '0;
  assign m_bready  = (w_state == W_RESP) ? w_sel : '0;
  assign m_awaddr  = {NUM_PORTS{aw_addr_q}};
  assign m_wdata   = {NUM_PORTS{w_data_q}};
  assign m_wstrb   = {NUM_PORTS{w_strb_q}};

  // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (s_awready) w_next = aw_hit ? W_FWD : W_BACK;
      W_FWD:  if ((aw_done || m_awready[w_idx_q]) && (w_done || m_wready[w_idx_q]))
                w_next = W_RESP;
      W_RESP: if (m_bvalid[w_idx_q]) w_next = W_BACK;
      W_BACK: if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    if (w_expire) w_next = W_BACK;
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_idx_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      case (w_state)
        W_IDLE: if (s_awready) begin
          aw_addr_q <= s_awaddr;
          w_data_q  <= s_wdata;
          w_strb_q  <= s_wstrb;
          w_idx_q   <= aw_idx;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          b_resp_q  <= aw_hit ? RESP_OKAY : RESP_DECERR;
        end
        W_FWD: begin
          aw_done <= aw_done | m_awready[w_idx_q];
          w_done  <= w_done | m_wready[w_idx_q];
        end
        W_RESP: if (m_bvalid[w_idx_q]) b_resp_q <= m_bresp[{w_idx_q, 1'b0} +: 2];
        default: ;
      endcase
      if (w_expire) b_resp_q <= RESP_SLVERR;
    end
  end

  // ---------------- read channel ----------------
  r_state_e                r_state, r_next;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [IDX_W-1:0]        r_idx_q, ar_idx;
  logic                    ar_hit;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [1:0]              r_resp_q;
  logic [NUM_PORTS-1:0]    r_sel;
  logic                    r_expire;

  assign ar_idx    = IDX_W'(decode_index(64'(s_araddr), WIN_BITS, IDX_W));
  assign ar_hit    = int'(ar_idx) < BASE_IDX_LIMIT;
  assign s_arready = (r_state == R_IDLE) && s_arvalid;
  assign s_rvalid  = (r_state == R_BACK);
  assign s_rdata   = r_data_q;
  assign s_rresp   = r_resp_q;

  assign r_sel     = NUM_PORTS'(1) << r_idx_q;
  assign m_arvalid = (r_state == R_FWD) ? r_sel : '0;
  assign m_rready  = (r_state == R_RESP) ? r_sel : '0;
  assign m_araddr  = {NUM_PORTS{ar_addr_q}};

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (s_arready) r_next = ar_hit ? R_FWD : R_BACK;
      R_FWD:  if (m_arready[r_idx_q]) r_next = R_RESP;
      R_RESP: if (m_rvalid[r_idx_q]) r_next = R_BACK;
      R_BACK: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    if (r_expire) r_next = R_BACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      r_idx_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      case (r_state)
        R_IDLE: if (s_arready) begin
          ar_addr_q <= s_araddr;
          r_idx_q   <= ar_idx;
          if (!ar_hit) begin
            r_data_q <= ERR_DATA;
            r_resp_q <= RESP_DECERR;
          end
        end
        R_RESP: if (m_rvalid[r_idx_q]) begin
          r_data_q <= m_rdata[{r_idx_q, 5'd0} +: DATA_WIDTH];
          r_resp_q <= m_rresp[{r_idx_q, 1'b0} +: 2];
        end
        default: ;
      endcase
      if (r_expire) begin
        r_data_q <= ERR_DATA;
        r_resp_q <= RESP_SLVERR;
      end
    end
  end

  // ---------------- watchdogs ----------------
`ifdef AXIL_DEMUX_TIMEOUT_EN
  logic w_wd_en, w_wd_clear, r_wd_en, r_wd_clear;

  // Restart the count whenever a channel enters FWD or RESP.
  assign w_wd_en    = (w_state == W_FWD) || (w_state == W_RESP);
  assign w_wd_clear = (w_next != w_state) && ((w_next == W_FWD) || (w_next == W_RESP));
  assign r_wd_en    = (r_state == R_FWD) || (r_state == R_RESP);
  assign r_wd_clear = (r_next != r_state) && ((r_next == R_FWD) || (r_next == R_RESP));

  axil_demux_wdog #(.TIMEOUT(TIMEOUT)) u_wdog_w (
    .clk(clk), .rst_n(rst_n), .clear(w_wd_clear), .enable(w_wd_en), .expire(w_expire)
  );
  axil_demux_wdog #(.TIMEOUT(TIMEOUT)) u_wdog_r (
    .clk(clk), .rst_n(rst_n), .clear(r_wd_clear), .enable(r_wd_en), .expire(r_expire)
  );
`else
  assign w_expire = 1'b0;
  assign r_expire = 1'b0;
`endif

endmodule

// File: tb/tb_axil_demux.sv
// Directed self-checking bench for axil_demux: a 4-port demux with behavioural slaves,
// plus a second instance with BASE_IDX_LIMIT=3 for decode-error reads.
module tb_axil_demux;
  import axil_demux_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Upstream of the main instance
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic          s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [31:0]   s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]    s_bresp, s_rresp;
  logic [31:0]   s_rdata;

  // Downstream of the main instance
  logic [NP*AW-1:0] m_awaddr, m_araddr;
  logic [NP*32-1:0] m_wdata, m_rdata;
  logic [NP*4-1:0]  m_wstrb;
  logic [NP*2-1:0]  m_bresp, m_rresp;
  logic [NP-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NP-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;

  // Limited-window instance
  logic [AW-1:0]    l_araddr = '0;
  logic             l_arvalid = 0, l_rready = 0;
  logic             l_awready, l_wready, l_bvalid, l_arready, l_rvalid;
  logic [1:0]       l_bresp, l_rresp;
  logic [31:0]      l_rdata;
  logic [NP*AW-1:0] l_m_awaddr, l_m_araddr;
  logic [NP*32-1:0] l_m_wdata;
  logic [NP*4-1:0]  l_m_wstrb;
  logic [NP-1:0]    l_m_awvalid, l_m_wvalid, l_m_bready, l_m_arvalid, l_m_rready;

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs
  int          aw_delay [NP] = '{default: 0};
  logic [NP-1:0] hang   = '0;
  logic [NP-1:0] hang_b = '0;

  axil_demux #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .WIN_BITS(12), .BASE_IDX_LIMIT(NP),
    .ERR_DATA(32'hDEAD_BEEF)
`ifdef AXIL_DEMUX_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  axil_demux #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .WIN_BITS(12), .BASE_IDX_LIMIT(3),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut_lim (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr('0), .s_awvalid(1'b0), .s_awready(l_awready),
    .s_wdata('0), .s_wstrb('0), .s_wvalid(1'b0), .s_wready(l_wready),
    .s_bresp(l_bresp), .s_bvalid(l_bvalid), .s_bready(1'b0),
    .s_araddr(l_araddr), .s_arvalid(l_arvalid), .s_arready(l_arready),
    .s_rdata(l_rdata), .s_rresp(l_rresp), .s_rvalid(l_rvalid), .s_rready(l_rready),
    .m_awaddr(l_m_awaddr), .m_awvalid(l_m_awvalid), .m_awready('0),
    .m_wdata(l_m_wdata), .m_wstrb(l_m_wstrb), .m_wvalid(l_m_wvalid), .m_wready('0),
    .m_bresp('0), .m_bvalid('0), .m_bready(l_m_bready),
    .m_araddr(l_m_araddr), .m_arvalid(l_m_arvalid), .m_arready('0),
    .m_rdata('0), .m_rresp('0), .m_rvalid('0), .m_rready(l_m_rready)
  );

  // Behavioural slaves: read data is 0xA000_0000 | port<<16 | addr[15:0]
  assign m_bresp = '0;
  assign m_rresp = '0;
  for (genvar i = 0; i < NP; i++) begin : g_slv
    logic        got_aw, got_w, b_pend, r_pend;
    int          aw_cnt;
    logic [31:0] r_data_q, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    assign m_awready[i] = m_awvalid[i] && !hang[i] && (aw_cnt >= aw_delay[i]);
    assign m_wready[i]  = !hang[i];
    assign m_arready[i] = !hang[i];
    assign m_bvalid[i]  = b_pend;
    assign m_rvalid[i]  = r_pend;
    assign m_rdata[i*32 +: 32] = r_data_q;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        got_aw <= 0; got_w <= 0; b_pend <= 0; r_pend <= 0; aw_cnt <= 0;
        r_data_q <= '0; cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
      end else begin
        if (m_awvalid[i] && !m_awready[i]) aw_cnt <= aw_cnt + 1;
        else aw_cnt <= 0;
        if (m_awvalid[i] && m_awready[i]) begin
          got_aw <= 1; cap_awaddr <= m_awaddr[i*AW +: AW];
        end
        if (m_wvalid[i] && m_wready[i]) begin
          got_w <= 1; cap_wdata <= m_wdata[i*32 +: 32]; cap_wstrb <= m_wstrb[i*4 +: 4];
        end
        if ((got_aw || (m_awvalid[i] && m_awready[i])) &&
            (got_w || (m_wvalid[i] && m_wready[i])) && !b_pend && !hang_b[i]) begin
          b_pend <= 1; got_aw <= 0; got_w <= 0;
        end
        if (m_bvalid[i] && m_bready[i]) b_pend <= 0;
        if (m_arvalid[i] && m_arready[i]) begin
          r_pend   <= 1;
          r_data_q <= 32'hA000_0000 | (32'(i) << 16) | {16'h0, m_araddr[i*AW +: 16]};
        end
        if (m_rvalid[i] && m_rready[i]) r_pend <= 0;
      end
    end
  end

  // Cycle counters of valid signals, sampled mid-cycle
  int aw_cyc [NP] = '{default: 0};
  int w_cyc  [NP] = '{default: 0};
  int ar_cyc [NP] = '{default: 0};
  int bv_cyc = 0;
  int lim_ar_cyc = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (m_awvalid[i]) aw_cyc[i] = aw_cyc[i] + 1;
      if (m_wvalid[i])  w_cyc[i]  = w_cyc[i] + 1;
      if (m_arvalid[i]) ar_cyc[i] = ar_cyc[i] + 1;
    end
    if (s_bvalid) bv_cyc = bv_cyc + 1;
    if (|l_m_arvalid) lim_ar_cyc = lim_ar_cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- transaction tasks ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int bready_delay,
                          output int lat, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_awaddr = addr; s_wdata = data; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    #1;
    n = 0;
    while (!(s_awready && s_wready) && n < 64) begin @(negedge clk); #1; n++; end
    checks++;
    if (!(s_awready && s_wready)) begin
      errors++; $display("FAIL wr_accept: awready=%0b wready=%0b required 1", s_awready, s_wready);
    end
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    lat = 1;
    while (!s_bvalid && lat < 64) begin @(negedge clk); lat++; end
    resp = s_bresp;
    for (int k = 0; k < bready_delay; k++) begin
      @(negedge clk);
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== resp) begin
        errors++; $display("FAIL b_hold: bvalid=%0b bresp=%0d required 1/%0d", s_bvalid, s_bresp, resp);
      end
    end
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int rready_delay,
                         output int lat, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_araddr = addr; s_arvalid = 1; s_rready = 0;
    #1;
    n = 0;
    while (!s_arready && n < 64) begin @(negedge clk); #1; n++; end
    checks++;
    if (!s_arready) begin
      errors++; $display("FAIL rd_accept: arready=%0b required 1", s_arready);
    end
    @(negedge clk);
    s_arvalid = 0;
    lat = 1;
    while (!s_rvalid && lat < 64) begin @(negedge clk); lat++; end
    data = s_rdata; resp = s_rresp;
    for (int k = 0; k < rready_delay; k++) begin
      @(negedge clk);
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== data) begin
        errors++; $display("FAIL r_hold: rvalid=%0b rdata=%0h required 1/%0h", s_rvalid, s_rdata, data);
      end
    end
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_s_handshake: got %b required 00000",
                         {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
    end
    checks++;
    if ({s_bresp, s_rresp} !== 4'b0 || s_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_s_payload: bresp=%0d rresp=%0d rdata=%0h required 0", s_bresp, s_rresp, s_rdata);
    end
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
      errors++; $display("FAIL reset_m_handshake: got %h required 0",
                         {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_bvalid, s_rvalid, m_awvalid, m_arvalid, l_rvalid, l_m_arvalid} !== '0) begin
      errors++; $display("FAIL post_reset_idle: outputs active after release");
    end
  endtask

  task automatic test_write_basic();
    int a0 [NP]; int lat; logic [1:0] resp;
    a0 = aw_cyc;
    do_write(32'h0000_2010, 32'h1234_5678, 0, lat, resp);
    repeat (2) @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (aw_cyc[i] - a0[i] !== ((i == 2) ? 1 : 0)) begin
        errors++; $display("FAIL wr_route port%0d: awvalid cycles=%0d required %0d", i, aw_cyc[i] - a0[i], (i == 2) ? 1 : 0);
      end
    end
    checks++;
    if (g_slv[2].cap_awaddr !== 32'h0000_2010 || g_slv[2].cap_wdata !== 32'h1234_5678 || g_slv[2].cap_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_payload: awaddr=%0h wdata=%0h strb=%0h required 2010/12345678/f",
                         g_slv[2].cap_awaddr, g_slv[2].cap_wdata, g_slv[2].cap_wstrb);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", lat); end
    checks++;
    if (resp !== RESP_OKAY) begin errors++; $display("FAIL wr_bresp: got %0d required 0", resp); end
    // Upper address bits do not affect routing and are forwarded untouched
    a0 = aw_cyc;
    do_write(32'h0001_2010, 32'h89AB_CDEF, 3, lat, resp);
    repeat (2) @(negedge clk);
    checks++;
    if (aw_cyc[2] - a0[2] !== 1 || g_slv[2].cap_awaddr !== 32'h0001_2010) begin
      errors++; $display("FAIL wr_upper_bits: port2 cycles=%0d awaddr=%0h required 1/00012010",
                         aw_cyc[2] - a0[2], g_slv[2].cap_awaddr);
    end
    checks++;
    if (lat !== 3 || resp !== RESP_OKAY) begin
      errors++; $display("FAIL wr_upper_resp: lat=%0d resp=%0d required 3/0", lat, resp);
    end
  endtask

  task automatic test_read_basic();
    int a0 [NP]; int lat; logic [31:0] data; logic [1:0] resp;
    a0 = ar_cyc;
    do_read(32'h0000_1008, 2, lat, data, resp);
    repeat (2) @(negedge clk);
    checks++;
    if (ar_cyc[1] - a0[1] !== 1 || ar_cyc[0] - a0[0] !== 0 || ar_cyc[2] - a0[2] !== 0 || ar_cyc[3] - a0[3] !== 0) begin
      errors++; $display("FAIL rd_route: port1 arvalid cycles=%0d required 1, others 0", ar_cyc[1] - a0[1]);
    end
    checks++;
    if (lat !== 3 || data !== 32'hA001_1008 || resp !== RESP_OKAY) begin
      errors++; $display("FAIL rd_basic: lat=%0d rdata=%0h rresp=%0d required 3/a0011008/0", lat, data, resp);
    end
  endtask

  task automatic test_decode_err();
    int c0; int n; int lat;
    c0 = lim_ar_cyc;
    @(negedge clk);
    l_araddr = 32'h0000_3004; l_arvalid = 1; l_rready = 0;
    #1;
    n = 0;
    while (!l_arready && n < 64) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    l_arvalid = 0;
    lat = 1;
    while (!l_rvalid && lat < 64) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dec_latency: got %0d required 1", lat); end
    checks++;
    if (l_rdata !== 32'hDEAD_BEEF || l_rresp !== RESP_DECERR) begin
      errors++; $display("FAIL dec_payload: rdata=%0h rresp=%0d required deadbeef/3", l_rdata, l_rresp);
    end
    l_rready = 1;
    @(negedge clk);
    l_rready = 0;
    @(negedge clk);
    checks++;
    if (lim_ar_cyc - c0 !== 0 || l_rvalid !== 1'b0) begin
      errors++; $display("FAIL dec_no_forward: arvalid cycles=%0d rvalid=%0b required 0/0", lim_ar_cyc - c0, l_rvalid);
    end
  endtask

  task automatic test_aw_delay();
    int a0 [NP]; int w0 [NP]; int b0; int lat; logic [1:0] resp;
    a0 = aw_cyc; w0 = w_cyc; b0 = bv_cyc;
    aw_delay[1] = 4;
    do_write(32'h0000_1000, 32'hCAFE_F00D, 0, lat, resp);
    repeat (4) @(negedge clk);
    aw_delay[1] = 0;
    checks++;
    if (w_cyc[1] - w0[1] !== 1) begin
      errors++; $display("FAIL dly_wvalid: cycles=%0d required 1", w_cyc[1] - w0[1]);
    end
    checks++;
    if (aw_cyc[1] - a0[1] !== 5) begin
      errors++; $display("FAIL dly_awvalid: cycles=%0d required 5", aw_cyc[1] - a0[1]);
    end
    checks++;
    if (bv_cyc - b0 !== 1) begin
      errors++; $display("FAIL dly_single_b: bvalid cycles=%0d required 1", bv_cyc - b0);
    end
    checks++;
    if (lat !== 7 || resp !== RESP_OKAY || g_slv[1].cap_wdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL dly_resp: lat=%0d resp=%0d wdata=%0h required 7/0/cafef00d", lat, resp, g_slv[1].cap_wdata);
    end
  endtask

  task automatic test_concurrent();
    int a0 [NP]; int r0 [NP]; int wl, rl; logic [1:0] wr, rr; logic [31:0] rd;
    a0 = aw_cyc; r0 = ar_cyc;
    fork
      do_write(32'h0000_3000, 32'h55AA_55AA, 0, wl, wr);
      do_read(32'h0000_0040, 0, rl, rd, rr);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (wl !== 3 || wr !== RESP_OKAY || g_slv[3].cap_wdata !== 32'h55AA_55AA || aw_cyc[3] - a0[3] !== 1) begin
      errors++; $display("FAIL conc_write: lat=%0d resp=%0d wdata=%0h required 3/0/55aa55aa", wl, wr, g_slv[3].cap_wdata);
    end
    checks++;
    if (rl !== 3 || rd !== 32'hA000_0040 || rr !== RESP_OKAY || ar_cyc[0] - r0[0] !== 1) begin
      errors++; $display("FAIL conc_read: lat=%0d rdata=%0h resp=%0d required 3/a0000040/0", rl, rd, rr);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [1:0] resp; logic [31:0] data;
    do_write(32'h0000_0004, 32'h0000_0001, 0, lat, resp);
    checks++;
    if (lat !== 3 || g_slv[0].cap_wdata !== 32'h0000_0001) begin
      errors++; $display("FAIL b2b_w0: lat=%0d wdata=%0h required 3/1", lat, g_slv[0].cap_wdata);
    end
    do_write(32'h0000_1004, 32'h0000_0002, 0, lat, resp);
    checks++;
    if (lat !== 3 || g_slv[1].cap_wdata !== 32'h0000_0002) begin
      errors++; $display("FAIL b2b_w1: lat=%0d wdata=%0h required 3/2", lat, g_slv[1].cap_wdata);
    end
    do_read(32'h0000_3ABC, 0, lat, data, resp);
    do_read(32'h0000_2010, 0, lat, data, resp);
    checks++;
    if (lat !== 3 || data !== 32'hA002_2010 || resp !== RESP_OKAY) begin
      errors++; $display("FAIL b2b_read: lat=%0d rdata=%0h required 3/a0022010", lat, data);
    end
  endtask

`ifdef AXIL_DEMUX_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [1:0] resp; logic [31:0] data;
    hang[2] = 1;
    do_read(32'h0000_2000, 0, lat, data, resp);
    hang[2] = 0;
    checks++;
    if (lat !== 17 || resp !== RESP_SLVERR || data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL timeout_read: lat=%0d resp=%0d rdata=%0h required 17/2/deadbeef", lat, resp, data);
    end
    do_read(32'h0000_1004, 0, lat, data, resp);
    checks++;
    if (lat !== 3 || resp !== RESP_OKAY || data !== 32'hA001_1004) begin
      errors++; $display("FAIL timeout_recover: lat=%0d resp=%0d rdata=%0h required 3/0/a0011004", lat, resp, data);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int lat; logic [1:0] resp;
    hang_b[0] = 1;
    @(negedge clk);
    s_awaddr = 32'h0000_0010; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    checks++;
    if (m_bready !== 4'b0001) begin
      errors++; $display("FAIL mid_in_resp: m_bready=%b required 0001", m_bready);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({m_bready, m_awvalid, m_wvalid, m_arvalid, m_rready} !== '0 ||
        {s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== '0 ||
        m_awaddr !== '0 || m_wdata !== '0 || s_bresp !== 2'b0 || s_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs: bready=%b bvalid=%0b awaddr0=%0h required all 0",
                         m_bready, s_bvalid, m_awaddr[31:0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    hang_b[0] = 0;
    do_write(32'h0000_0010, 32'h0BAD_F00D, 0, lat, resp);
    checks++;
    if (lat !== 3 || resp !== RESP_OKAY || g_slv[0].cap_wdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mid_fresh_write: lat=%0d resp=%0d wdata=%0h required 3/0/0badf00d", lat, resp, g_slv[0].cap_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_decode_err();
    test_aw_delay();
    test_concurrent();
    test_back_to_back();
`ifdef AXIL_DEMUX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_demux.md
# axil_demux

AXI-lite 1-to-N address demultiplexer with one outstanding write and one outstanding read. It sits between the shell's host-side AXI-lite master and the per-function slave ports, and routes each transaction to one port by address window. Out-of-window addresses are terminated locally with DECERR. Unused downstream ports are tied to the dummy AXI-lite slave.

## Interface
Parameters:
- NUM_PORTS, 4: number of downstream ports; must be ≥2 and a power of two.
- ADDR_WIDTH, 32: AXI-lite address width.
- WIN_BITS, 12: log2 of the per-port window size in bytes. The default gives 4 KiB per port.
- BASE_IDX_LIMIT, NUM_PORTS: number of populated windows. Any port index ≥ this value is a decode error.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on a decode error or a timeout.
- TIMEOUT, 1024: watchdog limit in cycles. Used only when AXIL_DEMUX_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: single clock for the whole block.
- rst_n, input, 1: reset. Asynchronous assert, active-low.
- s_axil, axi_lite.slave, CHANNEL=1: upstream port.
- m_axil, axi_lite.master, CHANNEL=NUM_PORTS: downstream ports. Per-port signals are packed, with port i at slice i.

## Operation
- Port index: idx = addr[WIN_BITS +: log2(NUM_PORTS)]. Address bits above the index are ignored.
- The forwarded address is the full upstream address; no offset is stripped.
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_BACK.
  - W_IDLE: wait for s_awvalid and s_wvalid together. When both are high, pulse s_awready and s_wready in that cycle and register awaddr, wdata, wstrb and idx.
  - From W_IDLE, a decoded idx below BASE_IDX_LIMIT goes to W_FWD. Otherwise go to W_BACK with bresp=2'b11.
  - W_FWD: drive m_awvalid[idx] and m_wvalid[idx]. Each valid drops independently once its ready is seen. Go to W_RESP when both have been accepted; simultaneous acceptance is allowed.
  - W_RESP: drive m_bready[idx]=1. On m_bvalid[idx], capture bresp and go to W_BACK.
  - W_BACK: drive s_bvalid=1 until s_bready is seen, then return to W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_BACK. The flow mirrors the write FSM.
  - R_IDLE: pulse s_arready on s_arvalid and register the address.
  - R_RESP: capture rdata and rresp.
  - Decode error: rdata=ERR_DATA and rresp=2'b11.
- The read and write FSMs are fully independent. Concurrent read and write are allowed, to the same port or to different ports.
- Signals to non-selected ports (valid, bready, rready) are 0. Address and data buses are broadcast to all ports.
- All s_* response outputs are registered; no combinational path from m_* to s_*.

## Timing
- Reset values: all valid and ready outputs are 0, bresp/rresp are 0, rdata is 0, and both FSMs are in IDLE.
  - Reset asserted mid-transaction aborts it immediately. Nothing is replayed after reset.
- Write to a slave with always-ready handshakes and an immediate response:
  - Cycle 0: accept.
  - Cycle 1: m_awvalid and m_wvalid.
  - Cycle 2: bready sampled with bvalid.
  - Cycle 3: s_bvalid.
  - Total latency is 3 cycles from accept to s_bvalid.
- Read with an always-ready slave: s_rvalid is asserted 3 cycles after accept.
- Decode error: s_bvalid or s_rvalid is asserted 1 cycle after accept.
- A new request is accepted no earlier than the cycle after the s_bready or s_rready handshake.
- s_bvalid and s_rvalid stay high, with stable payload, until the handshake completes.
- m_*valid signals stay high, with stable payload, until their ready is seen.

## Configuration
- AXIL_DEMUX_TIMEOUT_EN defined:
  - A watchdog counts cycles per FSM while in the FWD or RESP state.
  - The watchdog resets to 0 on each state entry.
  - When it reaches TIMEOUT, deassert all m_* valid/ready for that channel and go to BACK with resp=2'b10 (SLVERR). A read also returns rdata=ERR_DATA.
  - A late downstream response after a timeout is ignored.
- AXIL_DEMUX_TIMEOUT_EN undefined: no counter and no TIMEOUT parameter logic; a hung slave stalls its channel forever.

## Structure
- axil_demux_pkg holds:
  - the write and read state enums;
  - the response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11;
  - the index-decode function.
- One sub-module, axil_demux_wdog: the counter with inputs clear and enable, output expire, and parameter TIMEOUT. It is instantiated twice, once per channel, only under AXIL_DEMUX_TIMEOUT_EN.

## Test plan
- Write to 0x0000_2010 with wdata 0x1234_5678 and an always-ready slave. Required response:
  - only port 2 sees m_awvalid, with awaddr 0x2010 and wdata 0x1234_5678;
  - bresp=OKAY;
  - s_bvalid 3 cycles after accept.
- BASE_IDX_LIMIT=3, read from 0x3004. Required response:
  - no m_arvalid on any port;
  - s_rvalid 1 cycle after accept, with rdata=0xDEAD_BEEF and rresp=2'b11.
- Port 1 awready is delayed 4 cycles and wready arrives immediately. Required response:
  - m_wvalid[1] drops after 1 cycle;
  - m_awvalid[1] holds until awready;
  - a single s_bvalid follows.
- Read to port 0 issued in the same cycle as a write to port 3, both slaves responding. Required response: both complete with correct data, and neither channel blocks the other.
- Under AXIL_DEMUX_TIMEOUT_EN with TIMEOUT=16, a slave never asserts rvalid. Required response:
  - s_rvalid 16 cycles after R_FWD entry, with rresp=2'b10 and rdata=ERR_DATA;
  - the next read to a healthy port succeeds.
- rst_n is asserted while in W_RESP. Required response:
  - all outputs are 0 while reset is held;
  - after release, a fresh write completes normally.
